// File: rtl/load_store_unit_if.sv
// Request/response handshake and memory pin bundle for the load/store unit.
// The slave modport is the unit's view; master is the CPU/memory side.
interface load_store_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_wr;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [9:0]  req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [7:0]  mem_addr;
   logic [31:0] mem_data_in;
   logic        mem_wen;
   logic        mem_en;
   logic [31:0] mem_data_out;

   modport slave (
      input  req_valid, req_wr, req_size, req_unsigned, req_addr, req_wdata,
      output req_ready,
      output resp_valid, resp_rdata, resp_err,
      input  resp_ready,
      output mem_addr, mem_data_in, mem_wen, mem_en,
      input  mem_data_out
   );

   modport master (
      output req_valid, req_wr, req_size, req_unsigned, req_addr, req_wdata,
      input  req_ready,
      input  resp_valid, resp_rdata, resp_err,
      output resp_ready,
      input  mem_addr, mem_data_in, mem_wen, mem_en,
      output mem_data_out
   );
endinterface

// File: rtl/load_store_unit.sv
// Byte-addressed load/store initiator for a 256x32 falling-edge data memory.
// Sub-word stores are read-modify-write; loads are sign/zero extended.
//
// state  | meaning
// IDLE   | ready for a request
// RD     | memory read for a load
// RMW_RD | read old word for a byte/half store
// RMW_WR | write merged word
// WR     | write full word
// RESP   | response held until resp_ready
module load_store_unit (
   input  logic clk,
   input  logic rst_n,
   load_store_unit_if.slave lsu
);
   typedef enum logic [2:0] {IDLE, RD, RMW_RD, RMW_WR, WR, RESP} state_t;

   state_t      state, state_nxt;
   logic [1:0]  size_q;
   logic        uns_q;
   logic [9:0]  addr_q;
   logic [31:0] wdata_q;
   logic [31:0] old_q;
   logic [31:0] rdata_q;
   logic        err_q;
   logic        bad_req;
   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic [31:0] load_ext;
   logic [31:0] merged;

   assign bad_req = (lsu.req_size == 2'b11) ||
                    (lsu.req_size == 2'b01 && lsu.req_addr[0]) ||
                    (lsu.req_size == 2'b10 && lsu.req_addr[1:0] != 2'b00);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (lsu.req_valid) begin
               if (bad_req)                  state_nxt = RESP;
               else if (!lsu.req_wr)         state_nxt = RD;
               else if (lsu.req_size == 2'b10) state_nxt = WR;
               else                          state_nxt = RMW_RD;
            end
         end
         RD:      state_nxt = RESP;
         RMW_RD:  state_nxt = RMW_WR;
         RMW_WR:  state_nxt = RESP;
         WR:      state_nxt = RESP;
         RESP:    if (lsu.resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      byte_lane = lsu.mem_data_out[{addr_q[1:0], 3'b000} +: 8];
      half_lane = lsu.mem_data_out[{addr_q[1], 4'b0000} +: 16];
      load_ext  = lsu.mem_data_out;
      if (size_q == 2'b00)
         load_ext = uns_q ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
      else if (size_q == 2'b01)
         load_ext = uns_q ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
   end

   // Only the addressed lane of the previously read word is replaced.
   always_comb begin
      merged = old_q;
      if (size_q == 2'b00)
         merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      else
         merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         addr_q  <= 10'h0;
         wdata_q <= 32'h0;
         old_q   <= 32'h0;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (lsu.req_valid) begin
                  size_q  <= lsu.req_size;
                  uns_q   <= lsu.req_unsigned;
                  addr_q  <= lsu.req_addr;
                  wdata_q <= lsu.req_wdata;
                  rdata_q <= 32'h0;
                  err_q   <= bad_req;
               end
            end
            RD:      rdata_q <= load_ext;
            RMW_RD:  old_q   <= lsu.mem_data_out;
            default: ;
         endcase
      end
   end

   // Memory pins depend on registered state only, so reset drops them at once.
   always_comb begin
      lsu.mem_en      = 1'b0;
      lsu.mem_wen     = 1'b0;
      lsu.mem_addr    = 8'h0;
      lsu.mem_data_in = 32'h0;
      case (state)
         RD, RMW_RD: begin
            lsu.mem_en   = 1'b1;
            lsu.mem_addr = addr_q[9:2];
         end
         RMW_WR: begin
            lsu.mem_en      = 1'b1;
            lsu.mem_wen     = 1'b1;
            lsu.mem_addr    = addr_q[9:2];
            lsu.mem_data_in = merged;
         end
         WR: begin
            lsu.mem_en      = 1'b1;
            lsu.mem_wen     = 1'b1;
            lsu.mem_addr    = addr_q[9:2];
            lsu.mem_data_in = wdata_q;
         end
         default: ;
      endcase
   end

   assign lsu.req_ready  = (state == IDLE);
   assign lsu.resp_valid = (state == RESP);
   assign lsu.resp_rdata = rdata_q;
   assign lsu.resp_err   = err_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: falling-edge memory model, byte-array reference
// model, directed scenarios followed by randomized traffic.
module tb_load_store_unit;
   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   load_store_unit_if lif ();

   load_store_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .lsu   (lif.slave)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [0:255];
   logic [7:0]  ref_mem [0:1023];

   always @(negedge clk) begin
      if (lif.mem_en) begin
         if (lif.mem_wen) mem[lif.mem_addr] <= lif.mem_data_in;
         else             lif.mem_data_out <= mem[lif.mem_addr];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_word(input int w);
      return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
   endfunction

   // Reference: memory as a flat little-endian byte array.
   task automatic ref_access(input logic wr, input logic [1:0] size, input logic uns,
                             input logic [9:0] addr, input logic [31:0] wdata,
                             output logic err, output logic [31:0] rdata);
      int n;
      int a;
      logic [31:0] v;
      n = 1 << size;
      a = int'(addr);
      err = (size == 2'd3) || (a % n != 0);
      rdata = 32'h0;
      if (err) return;
      if (wr) begin
         v = wdata;
         for (int b = 0; b < n; b++) ref_mem[a + b] = v[8*b +: 8];
      end else begin
         v = 0;
         for (int b = 0; b < n; b++) v = v | (32'(ref_mem[a + b]) << (8*b));
         if (!uns && v[8*n-1]) for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
         rdata = v;
      end
   endtask

   task automatic do_req(input logic wr, input logic [1:0] size, input logic uns,
                         input logic [9:0] addr, input logic [31:0] wdata, input int hold);
      logic        exp_err;
      logic [31:0] exp_rd;
      logic [31:0] rd0;
      int exp_lat, exp_en, exp_wen, lat, en_n, wen_n;
      ref_access(wr, size, uns, addr, wdata, exp_err, exp_rd);
      exp_lat = exp_err ? 1 : (wr && size != 2'd2) ? 3 : 2;
      exp_en  = exp_err ? 0 : (wr && size != 2'd2) ? 2 : 1;
      exp_wen = (!exp_err && wr) ? 1 : 0;
      check("req_ready_idle", 32'(lif.req_ready), 32'd1);
      lif.req_wr = wr; lif.req_size = size; lif.req_unsigned = uns;
      lif.req_addr = addr; lif.req_wdata = wdata; lif.req_valid = 1'b1;
      @(posedge clk); #1;
      lif.req_valid = 1'b0;
      lif.req_addr = 10'($urandom); lif.req_wdata = $urandom;
      lat = 1; en_n = 0; wen_n = 0;
      while (!lif.resp_valid && lat < 8) begin
         check("req_ready_busy", 32'(lif.req_ready), 32'd0);
         if (lif.mem_en) begin
            en_n++;
            if (lif.mem_wen) wen_n++;
            check("mem_addr", 32'(lif.mem_addr), 32'(addr[9:2]));
         end
         @(posedge clk); #1;
         lat++;
      end
      check("latency", lat, exp_lat);
      check("mem_en_cycles", en_n, exp_en);
      check("mem_wen_cycles", wen_n, exp_wen);
      rd0 = lif.resp_rdata;
      for (int i = 0; i < hold; i++) begin
         check("hold_valid", 32'(lif.resp_valid), 32'd1);
         check("hold_rdata", lif.resp_rdata, rd0);
         check("hold_req_ready", 32'(lif.req_ready), 32'd0);
         check("hold_mem_en", 32'(lif.mem_en), 32'd0);
         @(posedge clk); #1;
      end
      check("resp_rdata", lif.resp_rdata, exp_rd);
      check("resp_err", 32'(lif.resp_err), 32'(exp_err));
      lif.resp_ready = 1'b1;
      @(posedge clk); #1;
      lif.resp_ready = 1'b0;
      check("resp_valid_drop", 32'(lif.resp_valid), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"},  32'(lif.req_ready),  32'd1);
      check({tag, "_resp_valid"}, 32'(lif.resp_valid), 32'd0);
      check({tag, "_resp_rdata"}, lif.resp_rdata,      32'd0);
      check({tag, "_resp_err"},   32'(lif.resp_err),   32'd0);
      check({tag, "_mem_en"},     32'(lif.mem_en),     32'd0);
      check({tag, "_mem_wen"},    32'(lif.mem_wen),    32'd0);
      check({tag, "_mem_addr"},   32'(lif.mem_addr),   32'd0);
      check({tag, "_mem_din"},    lif.mem_data_in,     32'd0);
   endtask

   initial begin
      logic [31:0] v;
      lif.req_valid = 1'b0; lif.req_wr = 1'b0; lif.req_size = 2'd0;
      lif.req_unsigned = 1'b0; lif.req_addr = 10'h0; lif.req_wdata = 32'h0;
      lif.resp_ready = 1'b0;
      lif.mem_data_out <= 32'h0;
      for (int i = 0; i < 256; i++) begin
         v = $urandom;
         mem[i] <= v;
         for (int b = 0; b < 4; b++) ref_mem[4*i + b] = v[8*b +: 8];
      end
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1 check_reset_outputs("reset");
      @(posedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Word store then load.
      do_req(1'b1, 2'd2, 1'b0, 10'h010, 32'hDEADBEEF, 0);
      check("ws_word", mem[8'h04], 32'hDEADBEEF);
      do_req(1'b0, 2'd2, 1'b0, 10'h010, 32'h0, 0);

      // Byte RMW over a known word, then signed/unsigned byte loads.
      do_req(1'b1, 2'd2, 1'b0, 10'h010, 32'h11223344, 0);
      do_req(1'b1, 2'd0, 1'b0, 10'h011, 32'h000000AA, 0);
      check("byte_rmw_word", mem[8'h04], 32'h1122AA44);
      do_req(1'b0, 2'd0, 1'b0, 10'h011, 32'h0, 0);
      do_req(1'b0, 2'd0, 1'b1, 10'h011, 32'h0, 0);

      // Upper half store and signed half load.
      v = mem[8'h08];
      do_req(1'b1, 2'd1, 1'b0, 10'h022, 32'h00008001, 0);
      check("half_rmw_word", mem[8'h08], {16'h8001, v[15:0]});
      do_req(1'b0, 2'd1, 1'b0, 10'h022, 32'h0, 0);

      // Errors: misaligned word, illegal size, misaligned half store.
      do_req(1'b0, 2'd2, 1'b0, 10'h013, 32'h0, 0);
      do_req(1'b0, 2'd3, 1'b0, 10'h014, 32'h0, 0);
      do_req(1'b1, 2'd1, 1'b0, 10'h031, 32'h5555, 0);

      // Backpressure on a load response.
      do_req(1'b0, 2'd2, 1'b0, 10'h010, 32'h0, 5);

      // Reset during WR before the memory's falling edge.
      lif.req_wr = 1'b1; lif.req_size = 2'd2; lif.req_unsigned = 1'b0;
      lif.req_addr = 10'h040; lif.req_wdata = 32'h12345678; lif.req_valid = 1'b1;
      @(posedge clk); #1;
      lif.req_valid = 1'b0;
      check("wr_mem_en", 32'(lif.mem_en), 32'd1);
      rst_n = 1'b0;
      #1 check_reset_outputs("midrst");
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rst_word_kept", mem[8'h10], ref_word(16));
      do_req(1'b0, 2'd2, 1'b0, 10'h040, 32'h0, 0);

      // Random traffic over a small window to force address reuse.
      for (int t = 0; t < 300; t++) begin
         do_req(1'($urandom), 2'($urandom), 1'($urandom), 10'($urandom_range(0, 63)),
                $urandom, int'($urandom_range(0, 2)));
      end
      for (int w = 0; w < 16; w++) check("final_word", mem[w], ref_word(w));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
endmodule
